voxel_weight_loader: RTL and testbench

Host-side write controller for the per-class weight RAMs of the voxel-bin classifier. Receives 4-byte weight-update frames over a valid/ready byte stream, validates them, and issues a single-cycle RAM write that is broadcast to every parallel read copy of the selected class. Writes are deferred while an inference pass (readout through systolic result) is in flight, so live scoring never reads a half-updated weight set. Sits between the UART/host byte path and the `weight_ram` write ports inside `voxel_bin_core`.

---
 rtl/voxel_bin_pkg.sv | 20 ++
 rtl/voxel_weight_loader.sv | 147 ++++++++++++++
 tb/tb_voxel_weight_loader.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/voxel_bin_pkg.sv
// Shared types and frame constants for the voxel-bin classifier host path.
package voxel_bin_pkg;

  typedef enum logic [2:0] {
    HDR,
    ADDR_HI,
    ADDR_LO,
    DATA,
    PEND
  } loader_state_t;

  localparam int HDR_MARKER_BIT = 7;
  localparam int CLASS_BITS     = 2;
  localparam int FRAME_BYTES    = 4;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/voxel_weight_loader.sv
// Host weight-update frame parser; issues one broadcast RAM write per valid
// frame, deferred while an inference pass is in flight.
module voxel_weight_loader
  import voxel_bin_pkg::*;
#(
  parameter int NUM_CLASSES    = 4,
  parameter int NUM_CELLS      = 1024,
  parameter int WEIGHT_BITS    = 8,
  parameter int TIMEOUT_CYCLES = 12000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    host_data,
  input  logic                          host_valid,
  output logic                          host_ready,
  input  logic                          infer_start,
  input  logic                          infer_done,
  output logic                          ram_we,
  output logic [NUM_CLASSES-1:0]        ram_class_sel,
  output logic [$clog2(NUM_CELLS)-1:0]  ram_addr,
  output logic [WEIGHT_BITS-1:0]        ram_din,
  output logic [15:0]                   wr_count,
  output logic [7:0]                    err_count,
  output logic                          infer_busy
);

  localparam int ADDR_W  = $clog2(NUM_CELLS);
  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
  // The address spans every byte between header and weight, so out-of-range
  // high bits are kept and rejected rather than silently truncated.
  localparam int ADDR_LATCH_BITS = 8 * (FRAME_BYTES - 2);

  loader_state_t              state;
  logic [CLASS_BITS-1:0]      cls_q;
  logic [ADDR_LATCH_BITS-1:0] addr_q;
  logic [WEIGHT_BITS-1:0]     data_q;
  logic [TIMER_W-1:0]         gap_timer;

  logic accept;
  logic grant;
  logic frame_ok;
  logic gap_expired;

  assign accept      = host_valid && host_ready;
  // A start pulse in the grant cycle wins: the pass must see the old weights.
  assign grant       = !infer_busy && !infer_start;
  assign frame_ok    = (32'(cls_q) < NUM_CLASSES) && (32'(addr_q) < NUM_CELLS);
  assign gap_expired = (gap_timer == TIMER_W'(1));

  // NOTE: every register here is assigned with <= so all state updates see the
  // same pre-edge values; blocking assignments would make results order-dependent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= HDR;
      cls_q         <= '0;
      addr_q        <= '0;
      data_q        <= '0;
      gap_timer     <= '0;
      host_ready    <= 1'b1;
      ram_we        <= 1'b0;
      ram_class_sel <= '0;
      ram_addr      <= '0;
      ram_din       <= '0;
      wr_count      <= '0;
      err_count     <= '0;
      infer_busy    <= 1'b0;
    end else begin
      infer_busy    <= infer_start || (infer_busy && !infer_done);
      ram_we        <= 1'b0;
      ram_class_sel <= '0;

      case (state)
        HDR: begin
          host_ready <= 1'b1;
          if (accept && host_data[HDR_MARKER_BIT]) begin
            cls_q     <= host_data[CLASS_BITS-1:0];
            gap_timer <= TIMER_W'(TIMEOUT_CYCLES);
            state     <= ADDR_HI;
          end
        end

        ADDR_HI: begin
          if (accept) begin
            addr_q[ADDR_LATCH_BITS-1:8] <= host_data;
            gap_timer                   <= TIMER_W'(TIMEOUT_CYCLES);
            state                       <= ADDR_LO;
          end else if (gap_expired) begin
            err_count <= sat_inc8(err_count);
            state     <= HDR;
          end else begin
            gap_timer <= gap_timer - TIMER_W'(1);
          end
        end

        ADDR_LO: begin
          if (accept) begin
            addr_q[7:0] <= host_data;
            gap_timer   <= TIMER_W'(TIMEOUT_CYCLES);
            state       <= DATA;
          end else if (gap_expired) begin
            err_count <= sat_inc8(err_count);
            state     <= HDR;
          end else begin
            gap_timer <= gap_timer - TIMER_W'(1);
          end
        end

        DATA: begin
          if (accept) begin
            data_q <= host_data[WEIGHT_BITS-1:0];
            if (frame_ok) begin
              host_ready <= 1'b0;
              state      <= PEND;
            end else begin
              err_count <= sat_inc8(err_count);
              state     <= HDR;
            end
          end else if (gap_expired) begin
            err_count <= sat_inc8(err_count);
            state     <= HDR;
          end else begin
            gap_timer <= gap_timer - TIMER_W'(1);
          end
        end

        PEND: begin
          host_ready <= 1'b0;
          if (grant) begin
            // host_ready stays low through the write cycle; HDR raises it next.
            ram_we        <= 1'b1;
            ram_class_sel <= NUM_CLASSES'(1) << cls_q;
            ram_addr      <= addr_q[ADDR_W-1:0];
            ram_din       <= data_q;
            wr_count      <= wr_count + 16'd1;
            state         <= HDR;
          end
        end

        default: begin
          host_ready <= 1'b1;
          state      <= HDR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_voxel_weight_loader.sv
// Directed self-checking bench for voxel_weight_loader.
module tb_voxel_weight_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  host_data;
  logic        host_valid;
  logic        host_ready;
  logic        infer_start;
  logic        infer_done;
  logic        ram_we;
  logic [3:0]  ram_class_sel;
  logic [9:0]  ram_addr;
  logic [7:0]  ram_din;
  logic [15:0] wr_count;
  logic [7:0]  err_count;
  logic        infer_busy;

  int tests  = 0;
  int failed = 0;
  int we_pulses = 0;

  voxel_weight_loader #(
    .NUM_CLASSES(4), .NUM_CELLS(1024), .WEIGHT_BITS(8), .TIMEOUT_CYCLES(12000)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .host_data(host_data), .host_valid(host_valid), .host_ready(host_ready),
    .infer_start(infer_start), .infer_done(infer_done),
    .ram_we(ram_we), .ram_class_sel(ram_class_sel), .ram_addr(ram_addr),
    .ram_din(ram_din), .wr_count(wr_count), .err_count(err_count),
    .infer_busy(infer_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (ram_we === 1'b1) we_pulses++;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called just after a negedge; returns just after the negedge following acceptance.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    host_data  = b;
    host_valid = 1'b1;
    while (host_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("ready_timeout", 32'(host_ready), 32'd1);
    @(negedge clk);
    host_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b0, b1, b2, b3);
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
    send_byte(b3);
  endtask

  task automatic wait_we(input int max_cyc, output int cyc);
    cyc = 0;
    while (ram_we !== 1'b1 && cyc < max_cyc) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"}, 32'(host_ready),    32'd1);
    check({tag, "_we"},    32'(ram_we),        32'd0);
    check({tag, "_sel"},   32'(ram_class_sel), 32'd0);
    check({tag, "_addr"},  32'(ram_addr),      32'd0);
    check({tag, "_din"},   32'(ram_din),       32'd0);
    check({tag, "_wr"},    32'(wr_count),      32'd0);
    check({tag, "_err"},   32'(err_count),     32'd0);
    check({tag, "_busy"},  32'(infer_busy),    32'd0);
  endtask

  initial begin
    int cyc;
    int bad;
    int pulses_snap;

    rst_n = 1'b0; host_data = '0; host_valid = 1'b0;
    infer_start = 1'b0; infer_done = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Basic write with exact latency and output stability.
    send_frame(8'h81, 8'h02, 8'h34, 8'h5A);
    check("t1_pend_ready", 32'(host_ready), 32'd0);
    check("t1_pend_we",    32'(ram_we),     32'd0);
    @(negedge clk);
    check("t1_we",   32'(ram_we),        32'd1);
    check("t1_sel",  32'(ram_class_sel), 32'h2);
    check("t1_addr", 32'(ram_addr),      32'h234);
    check("t1_din",  32'(ram_din),       32'h5A);
    check("t1_wr",   32'(wr_count),      32'd1);
    @(negedge clk);
    check("t1_we_off",    32'(ram_we),        32'd0);
    check("t1_sel_off",   32'(ram_class_sel), 32'd0);
    check("t1_addr_hold", 32'(ram_addr),      32'h234);
    check("t1_din_hold",  32'(ram_din),       32'h5A);
    check("t1_ready_back", 32'(host_ready),   32'd1);

    // Write deferred behind an inference pass.
    infer_start = 1'b1;
    @(negedge clk);
    infer_start = 1'b0;
    check("t2_busy_set", 32'(infer_busy), 32'd1);
    send_frame(8'h82, 8'h00, 8'h10, 8'h11);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      if (ram_we !== 1'b0 || host_ready !== 1'b0) bad++;
      @(negedge clk);
    end
    check("t2_no_write_while_busy", 32'(bad), 32'd0);
    check("t2_wr_hold", 32'(wr_count), 32'd1);
    infer_done = 1'b1;
    @(negedge clk);
    infer_done = 1'b0;
    check("t2_busy_clear", 32'(infer_busy), 32'd0);
    check("t2_we_not_yet", 32'(ram_we),     32'd0);
    @(negedge clk);
    check("t2_we",   32'(ram_we),        32'd1);
    check("t2_sel",  32'(ram_class_sel), 32'h4);
    check("t2_addr", 32'(ram_addr),      32'h010);
    check("t2_din",  32'(ram_din),       32'h11);
    check("t2_wr",   32'(wr_count),      32'd2);
    @(negedge clk);

    // Resync: header without marker is discarded.
    send_byte(8'h05);
    check("t3_resync_ready", 32'(host_ready), 32'd1);
    send_frame(8'h80, 8'h00, 8'h01, 8'hFF);
    wait_we(5, cyc);
    check("t3_latency", 32'(cyc),          32'd1);
    check("t3_sel",     32'(ram_class_sel), 32'h1);
    check("t3_addr",    32'(ram_addr),      32'h001);
    check("t3_din",     32'(ram_din),       32'hFF);
    check("t3_err",     32'(err_count),     32'd0);
    check("t3_wr",      32'(wr_count),      32'd3);
    @(negedge clk);

    // Out-of-range address is dropped.
    pulses_snap = we_pulses;
    send_frame(8'h80, 8'h07, 8'h00, 8'h12);
    check("t4_err",   32'(err_count),  32'd1);
    check("t4_ready", 32'(host_ready), 32'd1);
    repeat (4) @(negedge clk);
    check("t4_no_we", 32'(we_pulses - pulses_snap), 32'd0);
    check("t4_wr",    32'(wr_count),   32'd3);

    // Inference start collides with the would-be grant cycle.
    send_frame(8'h80, 8'h00, 8'h05, 8'h33);
    infer_start = 1'b1;
    @(negedge clk);
    infer_start = 1'b0;
    check("t5_collide_we",   32'(ram_we),     32'd0);
    check("t5_collide_busy", 32'(infer_busy), 32'd1);
    repeat (5) @(negedge clk);
    check("t5_still_pend", 32'(ram_we) + 32'(host_ready), 32'd0);
    infer_done = 1'b1;
    @(negedge clk);
    infer_done = 1'b0;
    wait_we(5, cyc);
    check("t5_latency", 32'(cyc),       32'd1);
    check("t5_addr",    32'(ram_addr),  32'h005);
    check("t5_wr",      32'(wr_count),  32'd4);
    @(negedge clk);
    check("t5_b2b_ready", 32'(host_ready), 32'd1);

    // Simultaneous start and done: a new pass started.
    infer_start = 1'b1; infer_done = 1'b1;
    @(negedge clk);
    infer_start = 1'b0; infer_done = 1'b0;
    check("t6_both_busy", 32'(infer_busy), 32'd1);
    infer_done = 1'b1;
    @(negedge clk);
    infer_done = 1'b0;
    check("t6_done_clear", 32'(infer_busy), 32'd0);

    // Gap timeout mid-frame, then a fresh frame at the boundary address.
    pulses_snap = we_pulses;
    send_byte(8'h81);
    send_byte(8'h00);
    repeat (11999) @(negedge clk);
    check("t7_no_early_timeout", 32'(err_count), 32'd1);
    repeat (2) @(negedge clk);
    check("t7_timeout_err", 32'(err_count), 32'd2);
    send_frame(8'h83, 8'h03, 8'hFF, 8'h77);
    wait_we(5, cyc);
    check("t7_latency", 32'(cyc),          32'd1);
    check("t7_sel",     32'(ram_class_sel), 32'h8);
    check("t7_addr",    32'(ram_addr),      32'h3FF);
    check("t7_din",     32'(ram_din),       32'h77);
    @(negedge clk);
    check("t7_one_write", 32'(we_pulses - pulses_snap), 32'd1);
    check("t7_wr",        32'(wr_count),    32'd5);

    // err_count saturation.
    for (int i = 0; i < 260; i++) send_frame(8'h80, 8'hFF, 8'h00, 8'h00);
    check("t8_err_sat", 32'(err_count), 32'd255);
    check("t8_wr",      32'(wr_count),  32'd5);

    // Reset while pending behind a busy inference.
    infer_start = 1'b1;
    @(negedge clk);
    infer_start = 1'b0;
    send_frame(8'h81, 8'h00, 8'h02, 8'h44);
    check("t9_pend_ready", 32'(host_ready), 32'd0);
    check("t9_pend_busy",  32'(infer_busy), 32'd1);
    pulses_snap = we_pulses;
    #1 rst_n = 1'b0;
    #1;
    check_reset_vals("t9_async");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("t9_no_we_after", 32'(we_pulses - pulses_snap), 32'd0);
    check("t9_wr",          32'(wr_count),  32'd0);
    check("t9_ready",       32'(host_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
